// File: rtl/video_stream_gen_pkg.sv
// Shared timing defaults, pattern encodings and pixel helpers for the
// binary-mask video stream generator.
package video_pkg;

  localparam int CW = 7;

  localparam int H_ACTIVE_DEF = 64;
  localparam int H_FP_DEF     = 4;
  localparam int H_SYNC_DEF   = 8;
  localparam int H_BP_DEF     = 7;
  localparam int V_ACTIVE_DEF = 64;
  localparam int V_FP_DEF     = 2;
  localparam int V_SYNC_DEF   = 3;
  localparam int V_BP_DEF     = 3;

  localparam int H_TOT = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOT = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef logic [CW-1:0] cnt_t;

  typedef enum logic [1:0] {
    PAT_CHECK  = 2'd0,
    PAT_BARS   = 2'd1,
    PAT_SQUARE = 2'd2,
    PAT_NOISE  = 2'd3
  } pattern_e;

  function automatic logic in_window(cnt_t val, cnt_t lo, cnt_t hi);
    return (val >= lo) && (val < hi);
  endfunction

  // Raw pattern pixel before blanking is applied.
  function automatic logic base_pixel(pattern_e pat, cnt_t h, cnt_t v,
                                      logic square, logic noise_hit);
    logic pix;
    case (pat)
      PAT_CHECK:  pix = h[3] ^ v[3];
      PAT_BARS:   pix = h[2];
      PAT_SQUARE: pix = square;
      default:    pix = square ^ noise_hit;
    endcase
    return pix;
  endfunction

endpackage

// File: rtl/video_stream_gen_if.sv
// Video output bus of the mask stream generator: timing strobes, pixel
// and the counter position that produced it.
interface video_stream_gen_if;
  import video_pkg::*;

  logic de;
  logic hsync;
  logic vsync;
  logic mask;
  cnt_t x;
  cnt_t y;
  logic frame_start;

  modport master (output de, hsync, vsync, mask, x, y, frame_start);
  modport slave  (input  de, hsync, vsync, mask, x, y, frame_start);

endinterface

// File: rtl/video_stream_gen_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used as the noise source;
// steps once per enabled clock and reloads the seed on reset.
module lfsr16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;
  logic        fb;

  always_comb begin
    fb  = q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10];
    q_d = ce ? {q_q[14:0], fb} : q_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= seed;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/video_stream_gen.sv
// Raster timing and 1-bit mask test-pattern source for the filter chain;
// every output is registered from the counter state of the previous ce cycle.
module video_stream_gen
  import video_pkg::*;
#(
  parameter int          H_ACTIVE  = H_ACTIVE_DEF,
  parameter int          H_FP      = H_FP_DEF,
  parameter int          H_SYNC    = H_SYNC_DEF,
  parameter int          H_BP      = H_BP_DEF,
  parameter int          V_ACTIVE  = V_ACTIVE_DEF,
  parameter int          V_FP      = V_FP_DEF,
  parameter int          V_SYNC    = V_SYNC_DEF,
  parameter int          V_BP      = V_BP_DEF,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [7:0]  NOISE_TH  = 8'd16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic [1:0]         pattern_sel,
  video_stream_gen_if.master vid
);

  localparam int LINE_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int FRAME_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam cnt_t H_ACT_C   = cnt_t'(H_ACTIVE);
  localparam cnt_t HS_BEG_C  = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_END_C  = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t H_LAST_C  = cnt_t'(LINE_TOT - 1);
  localparam cnt_t V_ACT_C   = cnt_t'(V_ACTIVE);
  localparam cnt_t VS_BEG_C  = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS_END_C  = cnt_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam cnt_t V_LAST_C  = cnt_t'(FRAME_TOT - 1);
  localparam cnt_t SQ_X_LO_C = cnt_t'(H_ACTIVE / 4);
  localparam cnt_t SQ_X_HI_C = cnt_t'((3 * H_ACTIVE) / 4);
  localparam cnt_t SQ_Y_LO_C = cnt_t'(V_ACTIVE / 4);
  localparam cnt_t SQ_Y_HI_C = cnt_t'((3 * V_ACTIVE) / 4);

  if (LINE_TOT > (1 << CW) || FRAME_TOT > (1 << CW)) begin : g_bad_size
    $error("video_stream_gen: line or frame total exceeds the 7-bit counters");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("video_stream_gen: LFSR_SEED must be nonzero");
  end

  cnt_t     h_cnt_q, h_cnt_d;
  cnt_t     v_cnt_q, v_cnt_d;
  pattern_e pat_q, pat_d;
  logic     de_q, de_d;
  logic     hsync_q, hsync_d;
  logic     vsync_q, vsync_d;
  logic     mask_q, mask_d;
  cnt_t     x_q, x_d;
  cnt_t     y_q, y_d;
  logic     frame_start_q, frame_start_d;

  logic        line_end;
  logic        frame_end;
  logic        square;
  logic        noise_hit;
  logic [15:0] lfsr_val;
  logic        lfsr_unused;

  // Next-state counters and the decode of the current counter position,
  // which becomes the registered output on the next enabled edge.
  always_comb begin
    line_end  = (h_cnt_q == H_LAST_C);
    frame_end = line_end && (v_cnt_q == V_LAST_C);

    h_cnt_d = line_end ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (line_end) begin
      v_cnt_d = (v_cnt_q == V_LAST_C) ? '0 : v_cnt_q + 1'b1;
    end

    pat_d = frame_end ? pattern_e'(pattern_sel) : pat_q;

    de_d    = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
    hsync_d = in_window(h_cnt_q, HS_BEG_C, HS_END_C);
    vsync_d = in_window(v_cnt_q, VS_BEG_C, VS_END_C);

    square    = in_window(h_cnt_q, SQ_X_LO_C, SQ_X_HI_C) &&
                in_window(v_cnt_q, SQ_Y_LO_C, SQ_Y_HI_C);
    noise_hit = (lfsr_val[7:0] < NOISE_TH);
    mask_d    = de_d && base_pixel(pat_q, h_cnt_q, v_cnt_q, square, noise_hit);

    x_d           = h_cnt_q;
    y_d           = v_cnt_q;
    frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      pat_q         <= PAT_CHECK;
      de_q          <= 1'b0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      mask_q        <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
    end else if (ce) begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      pat_q         <= pat_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      mask_q        <= mask_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
    end
  end

  // The noise source only moves on active pixels, so its sequence is
  // independent of blanking length and carries over between frames.
  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .ce   (ce & de_d),
    .seed (LFSR_SEED),
    .q    (lfsr_val)
  );

  assign lfsr_unused = ^lfsr_val[15:8];

  assign vid.de          = de_q;
  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.mask        = mask_q;
  assign vid.x           = x_q;
  assign vid.y           = y_q;
  assign vid.frame_start = frame_start_q;

endmodule

// File: tb/tb_video_stream_gen.sv
// Directed self-checking bench for video_stream_gen: timing, patterns,
// pattern latching, clock enable, noise repeatability and mid-frame reset.
module tb_video_stream_gen;

  localparam int LINE_CYC    = 83;
  localparam int FRAME_LINES = 72;
  localparam int FRAME_CYC   = 5976;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce = 1'b1;
  logic [1:0] pattern_sel = 2'd0;

  int checks = 0;
  int failures = 0;

  video_stream_gen_if vid ();

  video_stream_gen dut (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .pattern_sel (pattern_sel),
    .vid         (vid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut(input logic [1:0] sel);
    rst = 1'b1;
    ce = 1'b1;
    pattern_sel = sel;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic exp_de(input int h, input int v);
    return (h < 64) && (v < 64);
  endfunction

  function automatic logic exp_hs(input int h);
    return (h >= 68) && (h < 76);
  endfunction

  function automatic logic exp_vs(input int v);
    return (v >= 66) && (v < 69);
  endfunction

  function automatic logic exp_sq(input int h, input int v);
    return (h >= 16) && (h < 48) && (v >= 16) && (v < 48);
  endfunction

  function automatic logic exp_pix(input int pat, input int h, input int v);
    logic [6:0] hx;
    logic [6:0] vy;
    hx = 7'(h);
    vy = 7'(v);
    if (pat == 0) return hx[3] ^ vy[3];
    if (pat == 1) return hx[2];
    return exp_sq(h, v);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    ce = 1'b1;
    pattern_sel = 2'd0;
    tick();
    tick();
    checks++; if (vid.de !== 1'b0) begin failures++; $display("[TB] FAIL reset_de got=%b exp=0", vid.de); end
    checks++; if (vid.hsync !== 1'b0) begin failures++; $display("[TB] FAIL reset_hsync got=%b exp=0", vid.hsync); end
    checks++; if (vid.vsync !== 1'b0) begin failures++; $display("[TB] FAIL reset_vsync got=%b exp=0", vid.vsync); end
    checks++; if (vid.mask !== 1'b0) begin failures++; $display("[TB] FAIL reset_mask got=%b exp=0", vid.mask); end
    checks++; if (vid.x !== 7'd0) begin failures++; $display("[TB] FAIL reset_x got=%0d exp=0", vid.x); end
    checks++; if (vid.y !== 7'd0) begin failures++; $display("[TB] FAIL reset_y got=%0d exp=0", vid.y); end
    checks++; if (vid.frame_start !== 1'b0) begin failures++; $display("[TB] FAIL reset_fs got=%b exp=0", vid.frame_start); end
  endtask

  task automatic test_first_line();
    int err;
    int hs_high;
    int first_low;
    err = 0;
    hs_high = 0;
    first_low = -1;
    rst = 1'b0;
    for (int c = 1; c <= LINE_CYC; c++) begin
      tick();
      if (c == 1) begin
        checks++; if (vid.de !== 1'b1) begin failures++; $display("[TB] FAIL first_de got=%b exp=1", vid.de); end
        checks++; if (vid.frame_start !== 1'b1) begin failures++; $display("[TB] FAIL first_fs got=%b exp=1", vid.frame_start); end
        checks++; if (vid.x !== 7'd0 || vid.y !== 7'd0) begin failures++; $display("[TB] FAIL first_xy got=%0d,%0d exp=0,0", vid.x, vid.y); end
      end
      if (c == 68) begin
        checks++; if (vid.hsync !== 1'b0) begin failures++; $display("[TB] FAIL hsync_x67 got=%b exp=0", vid.hsync); end
      end
      if (c == 69) begin
        checks++; if (vid.hsync !== 1'b1) begin failures++; $display("[TB] FAIL hsync_x68 got=%b exp=1", vid.hsync); end
      end
      if (vid.x !== 7'(c - 1) || vid.y !== 7'd0) err++;
      if (vid.de !== exp_de(c - 1, 0) || vid.hsync !== exp_hs(c - 1) || vid.vsync !== 1'b0) err++;
      if (c > 1 && vid.frame_start !== 1'b0) err++;
      if (vid.hsync === 1'b1) hs_high++;
      if (vid.de === 1'b0 && first_low < 0) first_low = c;
    end
    checks++; if (err != 0) begin failures++; $display("[TB] FAIL line0_decode got=%0d bad cycles exp=0", err); end
    checks++; if (hs_high != 8) begin failures++; $display("[TB] FAIL hsync_width got=%0d exp=8", hs_high); end
    checks++; if (first_low != 65) begin failures++; $display("[TB] FAIL first_low_de got=%0d exp=65", first_low); end
  endtask

  task automatic test_frame_timing();
    int de_cnt, vs_cnt, vs_x, vs_y, blank_mask, err_mask, err_sync, err_xy, fs1, fs2;
    int pos, h, v;
    logic m00, m80, m88;
    de_cnt = 0; vs_cnt = 0; vs_x = -1; vs_y = -1; blank_mask = 0;
    err_mask = 0; err_sync = 0; err_xy = 0; fs1 = -1; fs2 = -1;
    m00 = 1'bx; m80 = 1'bx; m88 = 1'bx;
    reset_dut(2'd0);
    for (int c = 1; c <= FRAME_CYC + 1; c++) begin
      tick();
      pos = c - 1;
      h = pos % LINE_CYC;
      v = (pos / LINE_CYC) % FRAME_LINES;
      if (vid.frame_start === 1'b1) begin
        if (fs1 < 0) fs1 = c;
        else if (fs2 < 0) fs2 = c;
      end
      if (c <= FRAME_CYC) begin
        if (vid.de === 1'b1) de_cnt++;
        if (vid.vsync === 1'b1) begin
          vs_cnt++;
          if (vs_y < 0) begin vs_y = int'(vid.y); vs_x = int'(vid.x); end
        end
        if (vid.de !== 1'b1 && vid.mask !== 1'b0) blank_mask++;
        if (vid.mask !== (exp_de(h, v) & exp_pix(0, h, v))) err_mask++;
        if (vid.hsync !== exp_hs(h) || vid.vsync !== exp_vs(v) || vid.de !== exp_de(h, v)) err_sync++;
        if (vid.x !== 7'(h) || vid.y !== 7'(v)) err_xy++;
        if (h == 0 && v == 0) m00 = vid.mask;
        if (h == 8 && v == 0) m80 = vid.mask;
        if (h == 8 && v == 8) m88 = vid.mask;
      end
    end
    checks++; if (fs1 != 1) begin failures++; $display("[TB] FAIL fs_first got=%0d exp=1", fs1); end
    checks++; if (fs2 - fs1 != FRAME_CYC) begin failures++; $display("[TB] FAIL fs_spacing got=%0d exp=%0d", fs2 - fs1, FRAME_CYC); end
    checks++; if (de_cnt != 4096) begin failures++; $display("[TB] FAIL active_pixels got=%0d exp=4096", de_cnt); end
    checks++; if (vs_cnt != 249) begin failures++; $display("[TB] FAIL vsync_cycles got=%0d exp=249", vs_cnt); end
    checks++; if (vs_y != 66 || vs_x != 0) begin failures++; $display("[TB] FAIL vsync_start got=%0d,%0d exp=0,66", vs_x, vs_y); end
    checks++; if (blank_mask != 0) begin failures++; $display("[TB] FAIL blank_mask got=%0d exp=0", blank_mask); end
    checks++; if (err_mask != 0) begin failures++; $display("[TB] FAIL checker_frame got=%0d bad pixels exp=0", err_mask); end
    checks++; if (err_sync != 0) begin failures++; $display("[TB] FAIL sync_decode got=%0d bad cycles exp=0", err_sync); end
    checks++; if (err_xy != 0) begin failures++; $display("[TB] FAIL xy_track got=%0d bad cycles exp=0", err_xy); end
    checks++; if (m00 !== 1'b0) begin failures++; $display("[TB] FAIL check_0_0 got=%b exp=0", m00); end
    checks++; if (m80 !== 1'b1) begin failures++; $display("[TB] FAIL check_8_0 got=%b exp=1", m80); end
    checks++; if (m88 !== 1'b0) begin failures++; $display("[TB] FAIL check_8_8 got=%b exp=0", m88); end
  endtask

  task automatic test_pattern_switch();
    int err_mask, pos, f, r, h, v;
    logic m_keep, fs_f1, m_bars, sq_a, sq_b, sq_c, sq_d;
    err_mask = 0;
    m_keep = 1'bx; fs_f1 = 1'bx; m_bars = 1'bx;
    sq_a = 1'bx; sq_b = 1'bx; sq_c = 1'bx; sq_d = 1'bx;
    reset_dut(2'd0);
    for (int c = 1; c <= 3 * FRAME_CYC; c++) begin
      pos = c - 1;
      if (pos == 20 * LINE_CYC) pattern_sel = 2'd1;
      if (pos == FRAME_CYC + 20 * LINE_CYC) pattern_sel = 2'd2;
      tick();
      f = pos / FRAME_CYC;
      r = pos % FRAME_CYC;
      h = r % LINE_CYC;
      v = r / LINE_CYC;
      if (vid.mask !== (exp_de(h, v) & exp_pix(f, h, v))) err_mask++;
      if (f == 0 && h == 12 && v == 24) m_keep = vid.mask;
      if (f == 1 && h == 0 && v == 0) fs_f1 = vid.frame_start;
      if (f == 1 && h == 4 && v == 0) m_bars = vid.mask;
      if (f == 2 && h == 15 && v == 16) sq_a = vid.mask;
      if (f == 2 && h == 16 && v == 16) sq_b = vid.mask;
      if (f == 2 && h == 47 && v == 47) sq_c = vid.mask;
      if (f == 2 && h == 48 && v == 47) sq_d = vid.mask;
    end
    checks++; if (err_mask != 0) begin failures++; $display("[TB] FAIL switch_frames got=%0d bad pixels exp=0", err_mask); end
    checks++; if (m_keep !== 1'b0) begin failures++; $display("[TB] FAIL midframe_keep got=%b exp=0", m_keep); end
    checks++; if (fs_f1 !== 1'b1) begin failures++; $display("[TB] FAIL switch_fs got=%b exp=1", fs_f1); end
    checks++; if (m_bars !== 1'b1) begin failures++; $display("[TB] FAIL bars_4_0 got=%b exp=1", m_bars); end
    checks++; if (sq_a !== 1'b0) begin failures++; $display("[TB] FAIL square_15_16 got=%b exp=0", sq_a); end
    checks++; if (sq_b !== 1'b1) begin failures++; $display("[TB] FAIL square_16_16 got=%b exp=1", sq_b); end
    checks++; if (sq_c !== 1'b1) begin failures++; $display("[TB] FAIL square_47_47 got=%b exp=1", sq_c); end
    checks++; if (sq_d !== 1'b0) begin failures++; $display("[TB] FAIL square_48_47 got=%b exp=0", sq_d); end
  endtask

  task automatic test_ce_toggle();
    int err, n, pos, h, v, rise1, rise2;
    logic prev_fs;
    err = 0; rise1 = -1; rise2 = -1; prev_fs = 1'b0;
    reset_dut(2'd0);
    for (int c = 1; c <= 12000; c++) begin
      ce = (c % 2 == 1);
      tick();
      n = (c + 1) / 2;
      pos = n - 1;
      h = pos % LINE_CYC;
      v = (pos / LINE_CYC) % FRAME_LINES;
      if (vid.x !== 7'(h) || vid.y !== 7'(v)) err++;
      if (vid.de !== exp_de(h, v) || vid.hsync !== exp_hs(h) || vid.vsync !== exp_vs(v)) err++;
      if (vid.mask !== (exp_de(h, v) & exp_pix(0, h, v))) err++;
      if (vid.frame_start === 1'b1 && prev_fs !== 1'b1) begin
        if (rise1 < 0) rise1 = c;
        else if (rise2 < 0) rise2 = c;
      end
      prev_fs = vid.frame_start;
    end
    ce = 1'b1;
    checks++; if (err != 0) begin failures++; $display("[TB] FAIL ce_compressed got=%0d bad cycles exp=0", err); end
    checks++; if (rise1 != 1) begin failures++; $display("[TB] FAIL ce_fs_first got=%0d exp=1", rise1); end
    checks++; if (rise2 - rise1 != 2 * FRAME_CYC) begin failures++; $display("[TB] FAIL ce_fs_spacing got=%0d exp=%0d", rise2 - rise1, 2 * FRAME_CYC); end
  endtask

  task automatic run_noise(output int flips, output int mism, output int sig);
    logic [15:0] lf;
    logic d, sq, e;
    int pos, f, r, h, v;
    lf = 16'hACE1;
    flips = 0; mism = 0; sig = 0;
    reset_dut(2'd3);
    for (int c = 1; c <= 2 * FRAME_CYC; c++) begin
      tick();
      pos = c - 1;
      f = pos / FRAME_CYC;
      r = pos % FRAME_CYC;
      h = r % LINE_CYC;
      v = r / LINE_CYC;
      d = exp_de(h, v);
      sq = exp_sq(h, v);
      if (f == 0) e = d & exp_pix(0, h, v);
      else e = d & (sq ^ (lf[7:0] < 8'd16));
      if (d) lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
      if (vid.mask !== e) mism++;
      if (f == 1) begin
        if (d && vid.mask !== sq) flips++;
        sig = (sig * 33) ^ ((vid.mask === 1'b1) ? pos : 0);
      end
    end
  endtask

  task automatic test_noise();
    int f1, m1, s1, f2, m2, s2;
    run_noise(f1, m1, s1);
    run_noise(f2, m2, s2);
    checks++; if (m1 != 0) begin failures++; $display("[TB] FAIL noise_model got=%0d bad pixels exp=0", m1); end
    checks++; if (f1 < 200 || f1 > 320) begin failures++; $display("[TB] FAIL noise_flips got=%0d exp=200..320", f1); end
    checks++; if (f2 != f1) begin failures++; $display("[TB] FAIL noise_repeat_count got=%0d exp=%0d", f2, f1); end
    checks++; if (s2 != s1) begin failures++; $display("[TB] FAIL noise_repeat_sig got=%0h exp=%0h", s2, s1); end
  endtask

  task automatic test_reset_midframe();
    reset_dut(2'd1);
    for (int c = 1; c <= FRAME_CYC + 30 * LINE_CYC + 11; c++) begin
      tick();
    end
    checks++; if (vid.de !== 1'b1 || vid.y !== 7'd30) begin failures++; $display("[TB] FAIL pre_reset_pos got de=%b y=%0d exp de=1 y=30", vid.de, vid.y); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (vid.de !== 1'b0) begin failures++; $display("[TB] FAIL async_de got=%b exp=0", vid.de); end
    checks++; if (vid.hsync !== 1'b0 || vid.vsync !== 1'b0) begin failures++; $display("[TB] FAIL async_sync got=%b%b exp=00", vid.hsync, vid.vsync); end
    checks++; if (vid.x !== 7'd0 || vid.y !== 7'd0) begin failures++; $display("[TB] FAIL async_xy got=%0d,%0d exp=0,0", vid.x, vid.y); end
    checks++; if (vid.mask !== 1'b0 || vid.frame_start !== 1'b0) begin failures++; $display("[TB] FAIL async_mask_fs got=%b%b exp=00", vid.mask, vid.frame_start); end
    tick();
    tick();
    rst = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 1) begin
        checks++; if (vid.de !== 1'b1 || vid.frame_start !== 1'b1) begin failures++; $display("[TB] FAIL restart_de_fs got=%b%b exp=11", vid.de, vid.frame_start); end
        checks++; if (vid.x !== 7'd0 || vid.y !== 7'd0) begin failures++; $display("[TB] FAIL restart_xy got=%0d,%0d exp=0,0", vid.x, vid.y); end
      end
      if (c == 5) begin
        checks++; if (vid.mask !== 1'b0) begin failures++; $display("[TB] FAIL restart_pat_4_0 got=%b exp=0", vid.mask); end
      end
      if (c == 9) begin
        checks++; if (vid.mask !== 1'b1) begin failures++; $display("[TB] FAIL restart_pat_8_0 got=%b exp=1", vid.mask); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_frame_timing();
    test_pattern_switch();
    test_ce_toggle();
    test_noise();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
